// File: rtl/lcd_pkg.sv
// lcd_pkg: state encoding, LCD command constants and sizing helper shared by the LCD write arbiter.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD_SETUP,
        CMD_PULSE,
        CMD_WAIT,
        DAT_SETUP,
        DAT_PULSE,
        DAT_WAIT,
        DONE
    } state_t;

    localparam logic [7:0] SET_DDRAM     = 8'h80;
    localparam logic [7:0] START_2LINE   = 8'hC0;
    localparam logic [7:0] CLEAR_DISPLAY = 8'h01;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// lcd_rr_arbiter: combinational one-hot winner; round-robin, or fixed lowest-index priority with LCD_ARB_FIXED_PRIO_EN.
module lcd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_winner,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

`ifdef LCD_ARB_FIXED_PRIO_EN
    logic unused_last_winner;
    assign unused_last_winner = ^last_winner;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end
`else
    int   c;
    logic found;

    // Search begins just past the previous winner and wraps around.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        c     = 0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(last_winner) + k) % NUM_REQ;
            if (!found && req[c]) begin
                gnt[c] = 1'b1;
                idx    = c[IW-1:0];
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/lcd_field_arbiter.sv
// lcd_field_arbiter: arbitrates requesters and writes one character (DDRAM address, then data) on the LCD bus.
module lcd_field_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int EN_CYC   = 4,
    parameter int WAIT_CYC = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] addr,
    input  logic [8*NUM_REQ-1:0] wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 done,
    output logic                 busy,
    output logic                 rs,
    output logic                 rw,
    output logic                 enable,
    output logic [7:0]           data
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(max_int(EN_CYC, WAIT_CYC)) + 1;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [NUM_REQ-1:0] arb_gnt, gnt_n;
    logic [IW-1:0]      arb_idx, last_winner, lw_n;
    logic [7:0]         wd, wd_n, data_n;
    logic               done_n, rs_n, en_n;

    lcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req        (req),
        .last_winner(last_winner),
        .gnt        (arb_gnt),
        .idx        (arb_idx)
    );

    assign rw   = 1'b0;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            gnt         <= '0;
            done        <= 1'b0;
            rs          <= 1'b0;
            enable      <= 1'b0;
            data        <= '0;
            wd          <= '0;
            last_winner <= IW'(NUM_REQ - 1);
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            gnt         <= gnt_n;
            done        <= done_n;
            rs          <= rs_n;
            enable      <= en_n;
            data        <= data_n;
            wd          <= wd_n;
            last_winner <= lw_n;
        end
    end

    // Outputs are computed one cycle ahead so every bus signal comes straight from a flop.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_n   = '0;
        done_n  = 1'b0;
        rs_n    = rs;
        en_n    = 1'b0;
        data_n  = data;
        wd_n    = wd;
        lw_n    = last_winner;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = CMD_SETUP;
                    gnt_n   = arb_gnt;
                    lw_n    = arb_idx;
                    wd_n    = wdata[8*arb_idx +: 8];
                    data_n  = SET_DDRAM | {1'b0, addr[8*arb_idx +: 7]};
                    rs_n    = 1'b0;
                end
            end
            CMD_SETUP, DAT_SETUP: begin
                state_n = (state == CMD_SETUP) ? CMD_PULSE : DAT_PULSE;
                en_n    = 1'b1;
                cnt_n   = CW'(EN_CYC - 1);
            end
            CMD_PULSE, DAT_PULSE: begin
                if (cnt == '0) begin
                    state_n = (state == CMD_PULSE) ? CMD_WAIT : DAT_WAIT;
                    cnt_n   = CW'(WAIT_CYC - 1);
                end else begin
                    en_n  = 1'b1;
                    cnt_n = cnt - 1'b1;
                end
            end
            CMD_WAIT: begin
                if (cnt == '0) begin
                    state_n = DAT_SETUP;
                    data_n  = wd;
                    rs_n    = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DAT_WAIT: begin
                if (cnt == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                rs_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_field_arbiter.sv
// tb_lcd_field_arbiter: directed, self-checking bench for lcd_field_arbiter (NUM_REQ=4, EN_CYC=4, WAIT_CYC=8).
module tb_lcd_field_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic        done, busy, rs, rw, enable;
    logic [7:0]  data;

    int checks = 0;
    int errors = 0;

    lcd_field_arbiter #(.NUM_REQ(4), .EN_CYC(4), .WAIT_CYC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .rs    (rs),
        .rw    (rw),
        .enable(enable),
        .data  (data)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        int   n;
        logic found;
        logic [3:0] exp_g;

        // Reset state
        tick(2);
        reset = 1'b0;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rs", 32'(rs), 0);
        chk("rst_rw", 32'(rw), 0);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_data", 32'(data), 0);

        // Single transfer timeline: req0, addr 0D, wdata 35
        addr[7:0]  = 8'h0D;
        wdata[7:0] = 8'h35;
        req        = 4'b0001;
        for (int c = 1; c <= 27; c++) begin
            tick();
            if (c == 1) req = '0;
            chk($sformatf("t%0d_gnt", c), 32'(gnt), (c == 1) ? 32'h1 : 32'h0);
            chk($sformatf("t%0d_en", c), 32'(enable), ((c >= 2 && c <= 5) || (c >= 15 && c <= 18)) ? 1 : 0);
            chk($sformatf("t%0d_data", c), 32'(data), (c < 14) ? 32'h8D : 32'h35);
            chk($sformatf("t%0d_rs", c), 32'(rs), (c >= 14) ? 1 : 0);
            chk($sformatf("t%0d_done", c), 32'(done), (c == 27) ? 1 : 0);
            chk($sformatf("t%0d_busy", c), 32'(busy), 1);
            chk($sformatf("t%0d_rw", c), 32'(rw), 0);
        end
        tick();
        chk("t28_busy", 32'(busy), 0);
        chk("t28_rs", 32'(rs), 0);
        chk("t28_data", 32'(data), 32'h35);
        chk("t28_done", 32'(done), 0);

        // Four back-to-back transfers with all requesters asserted
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            found = 1'b0;
            n     = 0;
            while (!found && n < 60) begin
                tick();
                n++;
                if (gnt != 0) found = 1'b1;
            end
            chk($sformatf("rr%0d_found", t), 32'(found), 1);
`ifdef LCD_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'(1 << t);
`endif
            chk($sformatf("rr%0d_gnt", t), 32'(gnt), 32'(exp_g));
            if (t > 0) chk($sformatf("rr%0d_gap", t), n, 28);
        end

        // Late request during CMD_WAIT must not disturb the bus
        do_reset();
        addr[7:0]  = 8'h0D;
        wdata[7:0] = 8'h35;
        req        = 4'b0001;
        tick();
        req = '0;
        tick(6);
        req          = 4'b0010;
        addr[15:8]   = 8'h22;
        wdata[15:8]  = 8'h77;
        for (int c = 7; c <= 13; c++) begin
            chk($sformatf("w%0d_data", c), 32'(data), 32'h8D);
            chk($sformatf("w%0d_rs", c), 32'(rs), 0);
            tick();
        end
        chk("w14_data", 32'(data), 32'h35);
        chk("w14_rs", 32'(rs), 1);
        tick(13);
        chk("w27_done", 32'(done), 1);
        tick();
        chk("w28_busy", 32'(busy), 0);
        chk("w28_gnt", 32'(gnt), 0);
        tick();
        chk("w29_gnt", 32'(gnt), 32'h2);
        chk("w29_data", 32'(data), 32'hA2);
        req = '0;

        // Reset during DAT_PULSE
        tick(14);
        chk("rp_en", 32'(enable), 1);
        chk("rp_data", 32'(data), 32'h77);
        chk("rp_rs", 32'(rs), 1);
        reset = 1'b1;
        tick();
        chk("rp_en0", 32'(enable), 0);
        chk("rp_busy0", 32'(busy), 0);
        chk("rp_data0", 32'(data), 0);
        chk("rp_rs0", 32'(rs), 0);
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        chk("rp_regnt", 32'(gnt), 32'h1);

        // Address bit 7 is ignored in the command byte
        do_reset();
        addr[23:16] = 8'hCD;
        req         = 4'b0100;
        tick();
        chk("a_cd_gnt", 32'(gnt), 32'h4);
        chk("a_cd_data", 32'(data), 32'hCD);
        do_reset();
        addr[23:16] = 8'h4D;
        req         = 4'b0100;
        tick();
        chk("a_4d_data", 32'(data), 32'hCD);

        // One-cycle request pulse while busy is never granted
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        for (int c = 2; c <= 32; c++) begin
            tick();
            if (c == 10) req = 4'b1000;
            if (c == 11) req = '0;
            chk($sformatf("p%0d_gnt", c), 32'(gnt), 0);
            if (c >= 28) chk($sformatf("p%0d_busy", c), 32'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
